// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-source register-file write arbiter with starvation bound and pending scoreboard
module regfile_write_arbiter #(
    parameter int N          = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 A_Valid,
    output logic                 A_Ready,
    input  logic [$clog2(N)-1:0] A_Addr,
    input  logic [N-1:0]         A_Data,
    input  logic                 B_Valid,
    output logic                 B_Ready,
    input  logic [$clog2(N)-1:0] B_Addr,
    input  logic [N-1:0]         B_Data,
    input  logic                 Issue_Valid,
    input  logic [$clog2(N)-1:0] Issue_Addr,
    output logic [N-1:0]         Pending,
    output logic                 WriteEnable,
    output logic [$clog2(N)-1:0] WriteAddress,
    output logic [N-1:0]         WriteData
);

    localparam int AW = $clog2(N);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic          starve_full;
    logic          a_grant;
    logic          b_grant;
    logic          accept;
    logic [AW-1:0] win_addr;
    logic [N-1:0]  win_data;
    logic [N-1:0]  pending_next;

    // A wins unless B has been held off the maximum number of cycles.
    always_comb begin
        starve_full = (starve_cnt == SMAX);
        a_grant     = RESET_N && A_Valid && !(B_Valid && starve_full);
        b_grant     = RESET_N && B_Valid && (!A_Valid || starve_full);
        A_Ready     = a_grant;
        B_Ready     = b_grant;
        accept      = a_grant || b_grant;
        win_addr    = b_grant ? B_Addr : A_Addr;
        win_data    = b_grant ? B_Data : A_Data;
    end

    // Clear first, then set, so a re-issue on the write edge keeps the bit.
    always_comb begin
        pending_next = Pending;
        if (WriteEnable) begin
            pending_next[WriteAddress] = 1'b0;
        end
        if (Issue_Valid && (Issue_Addr != '0)) begin
            pending_next[Issue_Addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            starve_cnt   <= '0;
            WriteEnable  <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
            Pending      <= '0;
        end else begin
            if (B_Valid && !b_grant) begin
                starve_cnt <= starve_full ? starve_cnt : starve_cnt + SW'(1);
            end else begin
                starve_cnt <= '0;
            end

            // Writes to register 0 are accepted but discarded.
            if (accept && (win_addr != '0)) begin
                WriteEnable  <= 1'b1;
                WriteAddress <= win_addr;
                WriteData    <= win_data;
            end else begin
                WriteEnable  <= 1'b0;
            end

            Pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and randomized self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int N  = 32;
    localparam int SM = 4;
    localparam int AW = $clog2(N);

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          A_Valid, B_Valid, Issue_Valid;
    logic          A_Ready, B_Ready;
    logic [AW-1:0] A_Addr, B_Addr, Issue_Addr;
    logic [N-1:0]  A_Data, B_Data;
    logic [N-1:0]  Pending;
    logic          WriteEnable;
    logic [AW-1:0] WriteAddress;
    logic [N-1:0]  WriteData;

    always #5 CLK = ~CLK;

    regfile_write_arbiter #(.N(N), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Addr(A_Addr), .A_Data(A_Data),
        .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Addr(B_Addr), .B_Data(B_Data),
        .Issue_Valid(Issue_Valid), .Issue_Addr(Issue_Addr),
        .Pending(Pending), .WriteEnable(WriteEnable),
        .WriteAddress(WriteAddress), .WriteData(WriteData)
    );

    int checks = 0;
    int fails  = 0;

    // Reference state: held-off count for B, the write expected after the next edge, scoreboard bits.
    int          m_starve = 0;
    bit          m_we     = 0;
    bit [AW-1:0] m_wa     = '0;
    bit [N-1:0]  m_wd     = '0;
    bit [N-1:0]  m_pend   = '0;
    logic        obs_a, obs_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the following negedge.
    task automatic tick();
        bit ea, eb;
        #1;
        if (!RESET_N) begin
            ea = 0;
            eb = 0;
        end else if (A_Valid && !(B_Valid && m_starve == SM)) begin
            ea = 1;
            eb = 0;
        end else begin
            ea = 0;
            eb = B_Valid;
        end
        obs_a = A_Ready;
        obs_b = B_Ready;
        check("a_ready", {63'd0, A_Ready}, {63'd0, ea});
        check("b_ready", {63'd0, B_Ready}, {63'd0, eb});

        if (!RESET_N) begin
            m_starve = 0;
            m_we     = 0;
            m_wa     = '0;
            m_wd     = '0;
            m_pend   = '0;
        end else begin
            if (m_we) m_pend[m_wa] = 1'b0;
            if (Issue_Valid && Issue_Addr != 0) m_pend[Issue_Addr] = 1'b1;
            if (B_Valid && !eb) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            else m_starve = 0;
            m_we = 0;
            if (ea && A_Addr != 0) begin
                m_we = 1; m_wa = A_Addr; m_wd = A_Data;
            end
            if (eb && B_Addr != 0) begin
                m_we = 1; m_wa = B_Addr; m_wd = B_Data;
            end
        end

        @(negedge CLK);
        check("write_enable", {63'd0, WriteEnable}, {63'd0, m_we});
        check("write_address", 64'(WriteAddress), 64'(m_wa));
        check("write_data", 64'(WriteData), 64'(m_wd));
        check("pending", 64'(Pending), 64'(m_pend));
    endtask

    task automatic idle_inputs();
        A_Valid = 0; B_Valid = 0; Issue_Valid = 0;
        A_Addr = '0; B_Addr = '0; Issue_Addr = '0;
        A_Data = '0; B_Data = '0;
    endtask

    initial begin
        RESET_N = 0;
        idle_inputs();
        @(negedge CLK);
        tick();
        tick();
        check("reset_we", {63'd0, WriteEnable}, 64'd0);
        check("reset_pending", 64'(Pending), 64'd0);
        check("reset_wdata", 64'(WriteData), 64'd0);
        RESET_N = 1;

        // Single A write
        A_Valid = 1; A_Addr = 5; A_Data = 32'hDEAD_BEEF;
        tick();
        check("a_only_ready", {63'd0, obs_a}, 64'd1);
        check("a_only_we", {63'd0, WriteEnable}, 64'd1);
        check("a_only_addr", 64'(WriteAddress), 64'd5);
        check("a_only_data", 64'(WriteData), 64'hDEAD_BEEF);
        idle_inputs();
        tick();
        check("a_only_we_drop", {63'd0, WriteEnable}, 64'd0);

        // Continuous contention: B gets every fifth slot
        A_Valid = 1; A_Addr = 1; A_Data = 32'h1111;
        B_Valid = 1; B_Addr = 2; B_Data = 32'h2222;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("starve_b_grant_%0d", i), {63'd0, obs_b}, {63'd0, (i % 5) == 4});
        end
        idle_inputs();
        tick();

        // Pending scoreboard around a B write to r7
        Issue_Valid = 1; Issue_Addr = 7;
        tick();
        check("pend7_set", {63'd0, Pending[7]}, 64'd1);
        idle_inputs();
        B_Valid = 1; B_Addr = 7; B_Data = 32'h7777;
        tick();
        check("pend7_before_clear", {63'd0, Pending[7]}, 64'd1);
        idle_inputs();
        Issue_Valid = 1; Issue_Addr = 7;
        tick();
        check("pend7_set_wins", {63'd0, Pending[7]}, 64'd1);
        idle_inputs();
        B_Valid = 1; B_Addr = 7; B_Data = 32'h7878;
        tick();
        idle_inputs();
        tick();
        check("pend7_cleared", {63'd0, Pending[7]}, 64'd0);

        // Writes and issues to register 0 are discarded
        A_Valid = 1; A_Addr = 0; A_Data = 32'h1234;
        Issue_Valid = 1; Issue_Addr = 0;
        tick();
        check("r0_ready", {63'd0, obs_a}, 64'd1);
        check("r0_we", {63'd0, WriteEnable}, 64'd0);
        check("r0_pend", {63'd0, Pending[0]}, 64'd0);
        idle_inputs();

        // Reset right after an accepted write
        Issue_Valid = 1; Issue_Addr = 3;
        tick();
        idle_inputs();
        A_Valid = 1; A_Addr = 9; A_Data = 32'h9999;
        tick();
        check("pre_reset_we", {63'd0, WriteEnable}, 64'd1);
        RESET_N = 0; B_Valid = 1;
        tick();
        check("mid_reset_ready_a", {63'd0, obs_a}, 64'd0);
        check("mid_reset_ready_b", {63'd0, obs_b}, 64'd0);
        check("mid_reset_we", {63'd0, WriteEnable}, 64'd0);
        check("mid_reset_pend", 64'(Pending), 64'd0);
        RESET_N = 1;
        idle_inputs();

        // Back-to-back A writes to r1..r8
        for (int a = 1; a <= 8; a++) begin
            A_Valid = 1; A_Addr = AW'(a); A_Data = 32'hA000 + a;
            tick();
            check($sformatf("b2b_we_%0d", a), {63'd0, WriteEnable}, 64'd1);
            check($sformatf("b2b_addr_%0d", a), 64'(WriteAddress), 64'(a));
        end
        idle_inputs();
        tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            RESET_N     = ($urandom_range(0, 99) != 0);
            A_Valid     = ($urandom_range(0, 99) < 60);
            B_Valid     = ($urandom_range(0, 99) < 50);
            Issue_Valid = ($urandom_range(0, 99) < 40);
            A_Addr      = AW'($urandom);
            B_Addr      = ($urandom_range(0, 3) == 0) ? A_Addr : AW'($urandom);
            Issue_Addr  = ($urandom_range(0, 3) == 0) ? WriteAddress : AW'($urandom);
            A_Data      = $urandom;
            B_Data      = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning data width and register count; the address width is $clog2(N).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive cycles B may be held off.
REQ-003 SHALL have port CLK, input, width 1: single clock; all state updates on posedge.
REQ-004 SHALL have port RESET_N, input, width 1: reset, synchronous, active-low.
REQ-005 SHALL have port A_Valid, input, width 1: pipeline write-back request.
REQ-006 SHALL have port A_Ready, output, width 1: A request accepted this cycle.
REQ-007 SHALL have port A_Addr, input, width $clog2(N): A destination register.
REQ-008 SHALL have port A_Data, input, width N: A write data.
REQ-009 SHALL have port B_Valid, input, width 1: multi-cycle (mult/div) unit write request.
REQ-010 SHALL have port B_Ready, output, width 1: B request accepted this cycle.
REQ-011 SHALL have port B_Addr, input, width $clog2(N): B destination register.
REQ-012 SHALL have port B_Data, input, width N: B write data.
REQ-013 SHALL have port Issue_Valid, input, width 1: an instruction writing Issue_Addr was issued.
REQ-014 SHALL have port Issue_Addr, input, width $clog2(N): destination register of the issued instruction.
REQ-015 SHALL have port Pending, output, width N: bit r = 1 while a write to register r is outstanding.
REQ-016 SHALL have port WriteEnable, output, width 1: register-file write enable, registered.
REQ-017 SHALL have port WriteAddress, output, width $clog2(N): register-file write address, registered.
REQ-018 SHALL have port WriteData, output, width N: register-file write data, registered.

Function
REQ-019 SHALL form each handshake as X_Valid && X_Ready; X_Ready SHALL be combinational from the current valids and the starvation count, and at most one Ready SHALL be high per cycle.
REQ-020 SHALL grant A by default: when A_Valid=1 and starve_cnt<STARVE_MAX, A_Ready=1 and B_Ready=0.
REQ-021 SHALL grant B (B_Ready=1, A_Ready=0) when B_Valid=1 and either A_Valid=0 or starve_cnt==STARVE_MAX.
REQ-022 SHALL raise neither Ready when neither Valid is asserted.
REQ-023 SHALL keep starve_cnt (width $clog2(STARVE_MAX+1)): +1 per cycle while B_Valid=1 and B_Ready=0, saturating at STARVE_MAX; cleared to 0 when B is granted or B_Valid=0.
REQ-024 SHALL, on an accepted request with Addr!=0, load WriteAddress/WriteData from the winner at the next edge and set WriteEnable=1 for exactly that cycle; latency is one cycle from accept to WriteEnable.
REQ-025 SHALL, on an accepted request with Addr==0, complete the handshake, set WriteEnable=0, leave WriteAddress/WriteData unchanged and leave Pending unchanged.
REQ-026 SHALL drive WriteEnable=0 with WriteAddress/WriteData held at their previous values in any cycle following no accept.
REQ-027 SHALL sustain back-to-back accepts at one per cycle with no bubbles.
REQ-028 SHALL set Pending[r] at the edge where Issue_Valid=1 and Issue_Addr=r with r!=0; a re-issue to a register already pending keeps it at 1.
REQ-029 SHALL clear Pending[r] at the edge where WriteEnable=1 and WriteAddress=r, so the register-file write and the clear occur at the same edge.
REQ-030 SHALL let set win over clear when both occur on the same register on the same edge.
REQ-031 SHALL hold Pending[0] at 0 permanently.
REQ-032 SHALL NOT cancel a grant when A and B target the same address; the winner writes first and the loser writes in a later cycle (last writer wins in the array).

Reset
REQ-033 SHALL, with RESET_N=0 at a posedge, set WriteEnable=0, WriteAddress=0, WriteData=0, Pending=0 and starve_cnt=0.
REQ-034 SHALL hold A_Ready=0 and B_Ready=0 combinationally while RESET_N=0, with no handshake completing.
REQ-035 SHALL, on reset mid-operation, drop any write registered but not yet performed: WriteEnable is 0 in the cycle after the reset edge.
REQ-036 SHALL resume arbitration on the first cycle with RESET_N=1.

Verification
REQ-037 Test: A only, Addr=5, Data=32'hDEAD_BEEF -> A_Ready=1 same cycle; next cycle WriteEnable=1, WriteAddress=5, WriteData=32'hDEAD_BEEF; then WriteEnable=0.
REQ-038 Test: A and B both valid continuously, STARVE_MAX=4 -> A granted 4 cycles, B granted on the 5th cycle, then A regains priority and starve_cnt=0.
REQ-039 Test: Issue_Valid with Issue_Addr=7, then B writes Addr=7 -> Pending[7]=1 until the edge with WriteEnable=1 and WriteAddress=7, then 0; Issue to Addr=7 on that same edge -> Pending[7] stays 1.
REQ-040 Test: A Addr=0, Data=32'h1234 -> A_Ready=1; WriteEnable stays 0; Pending unchanged; Issue_Addr=0 never sets Pending[0].
REQ-041 Test: an accept to Addr=9, then RESET_N=0 at the next edge -> WriteEnable=0, Pending=0, both Ready=0 while reset is held.
REQ-042 Test: A valid every cycle to Addr 1..8 -> eight consecutive WriteEnable pulses in address order with no bubbles.
